gelu_poly_pipe: RTL and testbench

Pipelined, multi-lane successor to the combinational GELU polynomial stage. It computes s(x) = -K1*(x + K2*x^3) per lane, with K1 = 2.3125 and K2 = 0.046875, using shift-add constant multiplies. The block adds a valid/ready stream interface, a fixed 4-stage register pipeline, LANES parallel lanes, a selectable saturate/wrap mode and per-lane overflow flags. It sits between the GELU input formatter and the exponential/sigmoid unit.

---
 rtl/gelu_poly_pipe.sv | 113 +++++++++++
 tb/tb_gelu_poly_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gelu_poly_pipe.sv
// gelu_poly_pipe: LANES-wide, 4-stage pipelined s(x) = -K1*(x + K2*x^3) with
// K1 = 2.3125, K2 = 0.046875, a global-stall valid/ready stream and per-lane overflow flags.
module gelu_poly_pipe #(
  parameter int WIDTH = 32,
  parameter int Q     = 16,
  parameter int LANES = 4,
  parameter int SAT   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*WIDTH-1:0]   in_x,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   out_sx,
  output logic [LANES-1:0]         out_ovf
);

  localparam int W2 = 2 * WIDTH;
  localparam logic signed [W2-1:0] P_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [W2-1:0] P_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  // Returns {overflow, narrowed value}; out-of-range values clamp when SAT != 0, else wrap.
  function automatic logic [WIDTH:0] narrow(input logic signed [W2-1:0] v);
    logic             ovf;
    logic [WIDTH-1:0] res;
    ovf = (v > P_MAX) || (v < P_MIN);
    res = v[WIDTH-1:0];
    if ((SAT != 0) && ovf) res = v[W2-1] ? P_MIN[WIDTH-1:0] : P_MAX[WIDTH-1:0];
    return {ovf, res};
  endfunction

  logic w_adv;
  logic r_v1, r_v2, r_v3, r_v4;

  assign w_adv     = ~r_v4 | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_v4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_v4 <= 1'b0;
    end else if (w_adv) begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      r_v4 <= r_v3;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [WIDTH-1:0]   w_x;
    logic signed [W2-1:0]      w_xw, w_p2, w_p3;
    logic signed [WIDTH+1:0]   w_xe, w_x3e, w_inner;
    logic signed [WIDTH+3:0]   w_ie, w_s;
    logic        [WIDTH:0]     w_n2, w_n3, w_ni, w_ns;
    logic signed [WIDTH-1:0]   r_xa, r_x2, r_xb, r_x3, r_in, r_s;
    logic                      r_o1, r_o2, r_o3, r_o4;

    assign w_x  = in_x[g*WIDTH +: WIDTH];
    assign w_xw = {{WIDTH{w_x[WIDTH-1]}}, w_x};
    assign w_p2 = w_xw * w_xw;
    assign w_n2 = narrow(w_p2 >>> Q);

    assign w_p3 = {{WIDTH{r_x2[WIDTH-1]}}, r_x2} * {{WIDTH{r_xa[WIDTH-1]}}, r_xa};
    assign w_n3 = narrow(w_p3 >>> Q);

    // K2 = 1/32 + 1/64; headroom of two bits keeps the sum exact before narrowing.
    assign w_xe    = {{2{r_xb[WIDTH-1]}}, r_xb};
    assign w_x3e   = {{2{r_x3[WIDTH-1]}}, r_x3};
    assign w_inner = w_xe + (w_x3e >>> 5) + (w_x3e >>> 6);
    assign w_ni    = narrow({{(W2-WIDTH-2){w_inner[WIDTH+1]}}, w_inner});

    // K1 = 2 + 1/4 + 1/16, negated at full width so -min cannot wrap silently.
    assign w_ie = {{4{r_in[WIDTH-1]}}, r_in};
    assign w_s  = -((w_ie <<< 1) + (w_ie >>> 2) + (w_ie >>> 4));
    assign w_ns = narrow({{(W2-WIDTH-4){w_s[WIDTH+3]}}, w_s});

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_xa <= '0;
        r_x2 <= '0;
        r_xb <= '0;
        r_x3 <= '0;
        r_in <= '0;
        r_s  <= '0;
        r_o1 <= 1'b0;
        r_o2 <= 1'b0;
        r_o3 <= 1'b0;
        r_o4 <= 1'b0;
      end else if (w_adv) begin
        r_xa <= w_x;
        r_x2 <= w_n2[WIDTH-1:0];
        r_o1 <= w_n2[WIDTH];
        r_xb <= r_xa;
        r_x3 <= w_n3[WIDTH-1:0];
        r_o2 <= r_o1 | w_n3[WIDTH];
        r_in <= w_ni[WIDTH-1:0];
        r_o3 <= r_o2 | w_ni[WIDTH];
        r_s  <= w_ns[WIDTH-1:0];
        r_o4 <= r_o3 | w_ns[WIDTH];
      end
    end

    assign out_sx[g*WIDTH +: WIDTH] = r_s;
    assign out_ovf[g]               = r_o4;
  end

endmodule

// File: tb/tb_gelu_poly_pipe.sv
// Self-checking bench for gelu_poly_pipe: hand-computed vector table, stall/reset
// sequences and a random stream against a reference model, with SAT=1 and SAT=0 instances.
module tb_gelu_poly_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic         inValid;
  logic         outReady;
  logic [127:0] inX;
  logic         inReadyS, outValidS, inReadyW, outValidW;
  logic [127:0] outSxS, outSxW;
  logic [3:0]   outOvfS, outOvfW;

  int errors = 0;
  int checks = 0;

  gelu_poly_pipe #(.WIDTH(32), .Q(16), .LANES(4), .SAT(1)) dutSat (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyS), .in_x(inX),
    .out_valid(outValidS), .out_ready(outReady), .out_sx(outSxS), .out_ovf(outOvfS));

  gelu_poly_pipe #(.WIDTH(32), .Q(16), .LANES(4), .SAT(0)) dutWrap (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyW), .in_x(inX),
    .out_valid(outValidW), .out_ready(outReady), .out_sx(outSxW), .out_ovf(outOvfW));

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] x;
    logic [127:0] sSat;
    logic [3:0]   oSat;
    logic [127:0] sWrap;
    logic [3:0]   oWrap;
  } vec_t;

  vec_t         vecs[4];
  logic [127:0] beatX[8];
  logic [127:0] expS[8], expSO[8], expW[8], expWO[8];
  logic [127:0] qS[$], qSO[$], qW[$], qWO[$];
  logic [127:0] prevSx, mS, mSO, mW, mWO, rx;
  logic [3:0]   prevOvf;
  logic         held;
  int           lat, sent, rcv, cyc;

  function automatic logic [127:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic longint tbNarrow(input longint v, input bit sat, inout bit ovf);
    longint      r;
    logic [31:0] lo;
    r = v;
    if (v > 64'sd2147483647 || v < -64'sd2147483648) begin
      ovf = 1'b1;
      if (sat) r = (v > 0) ? 64'sd2147483647 : -64'sd2147483648;
      else begin
        lo = v[31:0];
        r  = longint'($signed(lo));
      end
    end
    return r;
  endfunction

  function automatic void modelBeat(input logic [127:0] x, input bit sat,
                                    output logic [127:0] s, output logic [127:0] ovf);
    logic [31:0] xl;
    longint      xv, x2, x3, inn, sv;
    bit          o;
    s   = '0;
    ovf = '0;
    for (int l = 0; l < 4; l++) begin
      xl  = x[l*32 +: 32];
      xv  = longint'($signed(xl));
      o   = 1'b0;
      x2  = tbNarrow((xv * xv) >>> 16, sat, o);
      x3  = tbNarrow((x2 * xv) >>> 16, sat, o);
      inn = tbNarrow(xv + (x3 >>> 5) + (x3 >>> 6), sat, o);
      sv  = tbNarrow(-((inn <<< 1) + (inn >>> 2) + (inn >>> 4)), sat, o);
      s[l*32 +: 32] = sv[31:0];
      ovf[l]        = o;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Drives one beat just after an edge, then counts edges until out_valid rises.
  task automatic applyStimulus(input logic [127:0] x, output int latency);
    @(posedge clk); #1;
    inX     = x;
    inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    latency = 1;
    while (!outValidS && latency < 20) begin
      @(posedge clk); #1;
      latency++;
    end
  endtask

  initial begin
    vecs[0] = '{pack4(65536, 0, -65536, 131072),
                pack4(-158656, 0, 158656, -359936), 4'b0000,
                pack4(-158656, 0, 158656, -359936), 4'b0000};
    vecs[1] = '{pack4(-1, 1, 0, 16777216),
                pack4(4, -2, 0, -271581178), 4'b1000,
                pack4(4, -2, 0, -38797312), 4'b1000};
    vecs[2] = '{pack4(32'h7FFFFFFF, -16777216, 32'h80000000, 229376),
                pack4(32'h80000000, 271581184, 2147483647, -835016), 4'b0111,
                pack4(-438304764, 38797312, 671088640, -835016), 4'b0111};
    vecs[3] = '{pack4(-32768, 3, -3, 100000),
                pack4(76664, -6, 8, -256484), 4'b0000,
                pack4(76664, -6, 8, -256484), 4'b0000};

    rst      = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b1;
    inX      = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", 128'(outValidS), 128'(0));
    checkOutput("reset_sx", outSxS, '0);
    checkOutput("reset_ovf", 128'(outOvfS), 128'(0));
    rst = 1'b0;
    $display("[TB] directed vectors");

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].x, lat);
      checkOutput($sformatf("vec%0d_latency", i), 128'(lat), 128'(4));
      checkOutput($sformatf("vec%0d_sx_sat", i), outSxS, vecs[i].sSat);
      checkOutput($sformatf("vec%0d_ovf_sat", i), 128'(outOvfS), 128'(vecs[i].oSat));
      checkOutput($sformatf("vec%0d_sx_wrap", i), outSxW, vecs[i].sWrap);
      checkOutput($sformatf("vec%0d_ovf_wrap", i), 128'(outOvfW), 128'(vecs[i].oWrap));
    end

    $display("[TB] stream with mid-stream stall");
    for (int i = 0; i < 8; i++) begin
      beatX[i] = pack4(i * 65536 - 200000, -(i * 12345), i * 7 - 20, i <<< 20);
      modelBeat(beatX[i], 1'b1, expS[i], expSO[i]);
      modelBeat(beatX[i], 1'b0, expW[i], expWO[i]);
    end
    sent = 0;
    rcv  = 0;
    cyc  = 0;
    held = 1'b0;
    while (rcv < 8 && cyc < 100) begin
      @(posedge clk); #1;
      outReady = !(cyc >= 7 && cyc <= 9);
      inValid  = (sent < 8);
      inX      = beatX[(sent < 8) ? sent : 0];
      @(negedge clk);
      if (held) begin
        checkOutput("stall_hold_valid", 128'(outValidS), 128'(1));
        checkOutput("stall_hold_sx", outSxS, prevSx);
        checkOutput("stall_hold_ovf", 128'(outOvfS), 128'(prevOvf));
      end
      if (!outReady) checkOutput("stall_in_ready", 128'(inReadyS), 128'(0));
      if (inValid && inReadyS) sent++;
      held    = outValidS && !outReady;
      prevSx  = outSxS;
      prevOvf = outOvfS;
      if (outValidS && outReady) begin
        checkOutput($sformatf("stream%0d_sx_sat", rcv), outSxS, expS[rcv]);
        checkOutput($sformatf("stream%0d_sx_wrap", rcv), outSxW, expW[rcv]);
        rcv++;
      end
      cyc++;
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    checkOutput("stream_count", 128'(rcv), 128'(8));
    repeat (6) @(posedge clk);
    #1;
    checkOutput("stream_no_dup", 128'(outValidS), 128'(0));

    $display("[TB] reset with beats in flight");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      inValid = 1'b1;
      inX     = beatX[k];
    end
    @(posedge clk); #1;
    inValid = 1'b0;
    checkOutput("pre_reset_valid", 128'(outValidS), 128'(1));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_valid", 128'(outValidS), 128'(0));
    checkOutput("async_reset_sx", outSxS, '0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("post_reset_idle", 128'(outValidS), 128'(0));
    end
    applyStimulus(vecs[0].x, lat);
    checkOutput("post_reset_latency", 128'(lat), 128'(4));
    checkOutput("post_reset_sx", outSxS, vecs[0].sSat);

    $display("[TB] random stream against model");
    sent = 0;
    cyc  = 0;
    while ((sent < 300 || qS.size() != 0) && cyc < 5000) begin
      @(posedge clk); #1;
      outReady = ($urandom_range(0, 3) != 0);
      inValid  = (sent < 300) && ($urandom_range(0, 4) != 0);
      for (int l = 0; l < 4; l++)
        rx[l*32 +: 32] = ($urandom_range(0, 3) == 0) ? $urandom
                         : 32'($urandom_range(0, 2000000)) - 32'd1000000;
      inX = rx;
      @(negedge clk);
      if (outValidS && outReady) begin
        if (qS.size() == 0) checkOutput("rand_unexpected_beat", 128'(1), 128'(0));
        else begin
          checkOutput("rand_sx_sat", outSxS, qS.pop_front());
          checkOutput("rand_ovf_sat", 128'(outOvfS), qSO.pop_front());
          checkOutput("rand_sx_wrap", outSxW, qW.pop_front());
          checkOutput("rand_ovf_wrap", 128'(outOvfW), qWO.pop_front());
        end
      end
      if (inValid && inReadyS) begin
        modelBeat(inX, 1'b1, mS, mSO);
        modelBeat(inX, 1'b0, mW, mWO);
        qS.push_back(mS);
        qSO.push_back(mSO);
        qW.push_back(mW);
        qWO.push_back(mWO);
        sent++;
      end
      cyc++;
    end
    inValid = 1'b0;
    checkOutput("rand_all_sent", 128'(sent), 128'(300));
    checkOutput("rand_drained", 128'(qS.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
